// File: rtl/mult_pkg.sv
// ============================================================================
// Module      : mult_pkg
// Description : Shared state encoding and sizing helper for the sequential
//               shift-add multiplier (mult_seq / mult_seq_dp).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_pkg;

  // Control FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

  // Iteration counter width: wide enough to hold WIDTH itself, because the
  // counter is still incremented on the final RUN step.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mult_seq_dp.sv
// ============================================================================
// Module      : mult_seq_dp
// Description : Shift-add datapath for mult_seq. Holds the accumulator,
//               shifted multiplicand, shifted multiplier and the registered
//               product. Driven by load/step/last strobes from the controller.
//               Build option MULT_SIGNED_EN: two's-complement operands; the
//               loop runs on magnitudes and the sign is applied when the
//               product register is loaded.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_seq_dp
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic                 last_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   prod_o
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [PW-1:0]    sum;
  logic [PW-1:0]    result;
  logic [WIDTH-1:0] mag_a, mag_b;

`ifdef MULT_SIGNED_EN
  logic sign_q, sign_d;

  // Loop operates on magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1), which
  // still fits as an unsigned WIDTH-bit value.
  assign mag_a  = a_i[WIDTH-1] ? (~a_i + 1'b1) : a_i;
  assign mag_b  = b_i[WIDTH-1] ? (~b_i + 1'b1) : b_i;
  assign sign_d = load_i ? (a_i[WIDTH-1] ^ b_i[WIDTH-1]) : sign_q;
  // Sign correction is folded into the product register load so the
  // RUN->DONE latency is the same as the unsigned build.
  assign result = sign_q ? (~sum + 1'b1) : sum;

  // Product sign captured with the operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sign_q <= 1'b0;
    else     sign_q <= sign_d;
  end
`else
  assign mag_a  = a_i;
  assign mag_b  = b_i;
  assign result = sum;
`endif

  // Accumulator plus the current partial product (modulo 2^PW)
  assign sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Next-state for load (operand capture) and step (one shift-add iteration)
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    if (load_i) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, mag_a};
      mplier_d = mag_b;
    end else if (step_i) begin
      acc_d    = sum;
      mcand_d  = {mcand_q[PW-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
      // Product register holds its value until the next final step
      if (last_i) prod_d = result;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

  assign prod_o = prod_q;

endmodule

`default_nettype wire

// File: rtl/mult_seq.sv
// ============================================================================
// Module      : mult_seq
// Description : Multi-cycle shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH,
//               with valid/ready handshakes on operand and product sides.
//               IDLE accepts operands, RUN performs exactly WIDTH shift-add
//               steps, DONE presents the product until out_ready.
//               Build option MULT_SIGNED_EN: two's-complement operation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out,
  output logic                 busy
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load, step, last;

  // Next-state, counter and datapath strobes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // No early exit on zero operands: always WIDTH steps
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          last    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and iteration counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake outputs decode directly from the state register
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);

  mult_seq_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .step_i (step),
    .last_i (last),
    .a_i    (a),
    .b_i    (b),
    .prod_o (out)
  );

endmodule

`default_nettype wire

// File: tb/tb_mult_seq.sv
// ============================================================================
// Module      : tb_mult_seq
// Description : Self-checking bench for mult_seq: directed vector table,
//               hand-written busy/reset sequences and a randomized sweep
//               against an arithmetic reference model. Honours
//               MULT_SIGNED_EN for the expected products.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mult_seq;

  localparam int WIDTH = 8;
  localparam int PW    = 2 * WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [PW-1:0]    out;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    int               hold;   // cycles out_ready stays low in DONE
    logic [PW-1:0]    want;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  mult_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  // Reference: plain integer product, truncated to the output width
  function automatic logic [PW-1:0] ref_mul(input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y);
    longint px, py, p;
`ifdef MULT_SIGNED_EN
    px = longint'($signed(x));
    py = longint'($signed(y));
`else
    px = longint'(x);
    py = longint'(y);
`endif
    p = px * py;
    return p[PW-1:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (in_ready !== 1'b1) check({tag, "_ready_timeout"}, 64'(in_ready), 64'd1);
  endtask

  // One full transaction: accept, wait for DONE, stall `hold` cycles, handshake
  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input int hold, input logic [PW-1:0] want,
                        input string tag);
    int lat;
    wait_ready(tag);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick();                         // accept edge
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 50) begin
      // operand churn and stray out_ready during RUN must be ignored
      a         = WIDTH'($urandom);
      b         = WIDTH'($urandom);
      out_ready = 1'($urandom);
      tick();
      lat++;
    end
    out_ready = 1'b0;
    // Accept cycle is cycle 0; product must be valid in cycle WIDTH+1
    check({tag, "_latency_cycles"}, 64'(lat + 1), 64'(WIDTH + 1));
    check({tag, "_product"}, 64'(out), 64'(want));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_stall_out"}, 64'(out), 64'(want));
      check({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_stall_in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();                         // handshake edge
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
    check({tag, "_out_hold"}, 64'(out), 64'(want));
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;

    // ---- directed vector table ----
    vecs.push_back('{va: 8'd3,   vb: 8'd5,   hold: 0, want: 16'd15});
    vecs.push_back('{va: 8'd0,   vb: 8'd200, hold: 0, want: 16'd0});
    vecs.push_back('{va: 8'd12,  vb: 8'd10,  hold: 5, want: 16'd120});
`ifdef MULT_SIGNED_EN
    vecs.push_back('{va: 8'hFD,  vb: 8'd5,   hold: 0, want: 16'hFFF1});
    vecs.push_back('{va: 8'h80,  vb: 8'h80,  hold: 1, want: 16'h4000});
    vecs.push_back('{va: 8'd127, vb: 8'hFF,  hold: 0, want: 16'hFF81});
`else
    vecs.push_back('{va: 8'd255, vb: 8'd255, hold: 0, want: 16'd65025});
    vecs.push_back('{va: 8'd128, vb: 8'd2,   hold: 2, want: 16'd256});
`endif

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_out",       64'(out),       64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    foreach (vecs[i]) run_op(vecs[i].va, vecs[i].vb, vecs[i].hold, vecs[i].want,
                             $sformatf("vec%0d", i));

    // ---- in_valid while busy: only the first operands count ----
    wait_ready("busy");
    a = 8'd2; b = 8'd9; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    a = 8'd7; b = 8'd7;             // in_valid stays high through RUN and DONE
    check("busy_flag", 64'(busy), 64'd1);
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin tick(); n++; end
    check("busy_product", 64'(out), 64'd18);
    check("busy_done_in_ready", 64'(in_ready), 64'd0);
    tick();
    check("busy_done_held", 64'(out_valid), 64'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    check("busy_no_capture", 64'(busy), 64'd0);
    check("busy_out_hold", 64'(out), 64'd18);

    // ---- asynchronous reset in the middle of RUN ----
    wait_ready("rstrun");
    a = 8'd9; b = 8'd11; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("rstrun_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("rstrun_in_ready",  64'(in_ready),  64'd1);
    check("rstrun_out_valid", 64'(out_valid), 64'd0);
    check("rstrun_busy",      64'(busy),      64'd0);
    check("rstrun_out",       64'(out),       64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    run_op(8'd6, 8'd7, 0, 16'd42, "after_rst");

    // ---- randomized sweep with back-pressure ----
    for (int k = 0; k < 200; k++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      run_op(ra, rb, int'($urandom_range(0, 3)), ref_mul(ra, rb),
             $sformatf("rnd%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time guard so the run always terminates
  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
